// File: rtl/edge_pkg.sv
// Shared definitions for the multi-channel edge detector.
// Holds the edge_mode encodings, parameter limits and small helper functions.
package edge_pkg;

   typedef enum logic [1:0] {
      EDGE_NONE = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_mode_e;

   localparam int unsigned WIDTH_MIN         = 1;
   localparam int unsigned WIDTH_MAX         = 32;
   localparam int unsigned SYNC_STAGES_MIN   = 0;
   localparam int unsigned SYNC_STAGES_MAX   = 4;
   localparam int unsigned FILTER_CYCLES_MIN = 1;
   localparam int unsigned FILTER_CYCLES_MAX = 65535;

   // The counter only has to reach FILTER_CYCLES-1, but a zero-width vector is illegal.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      return (cycles <= 1) ? 1 : $clog2(cycles);
   endfunction

   function automatic logic edge_qualifies(input edge_mode_e mode,
                                           input logic       rise,
                                           input logic       fall);
      return (rise && (mode == EDGE_RISE || mode == EDGE_BOTH)) ||
             (fall && (mode == EDGE_FALL || mode == EDGE_BOTH));
   endfunction

endpackage

// File: rtl/edge_chan.sv
// One channel of the edge detector: synchroniser, glitch filter,
// edge pulses and the sticky event/overflow flags.
module edge_chan
   import edge_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned FILTER_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       sig_i,
   input  logic [1:0] mode_i,
   input  logic       clr_i,
   output logic       level_o,
   output logic       rising_o,
   output logic       falling_o,
   output logic       event_o,
   output logic       overflow_o
);

   localparam int unsigned          CNT_W   = cnt_width(FILTER_CYCLES);
   localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

   logic             s;
   logic             level_q, level_d;
   logic             prev_level_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             event_q, event_d;
   logic             overflow_q, overflow_d;
   logic             rising, falling, qual;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign s = sig_i;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q, sync_d;

         always_comb begin
            sync_d    = sync_q;
            sync_d[0] = sig_i;
            for (int k = 1; k < int'(SYNC_STAGES); k++) begin
               sync_d[k] = sync_q[k-1];
            end
         end

         // Reset preloads the chain with the live input so a static level never looks like an edge.
         always_ff @(posedge clk) begin
            if (!reset_n) begin
               sync_q <= {SYNC_STAGES{sig_i}};
            end else begin
               sync_q <= sync_d;
            end
         end

         assign s = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      if (s == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         level_d = s;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign rising  = level_q & ~prev_level_q;
   assign falling = ~level_q & prev_level_q;
   assign qual    = edge_qualifies(edge_mode_e'(mode_i), rising, falling);

   // A new qualifying edge beats a simultaneous clear, and then counts as fresh rather than lost.
   always_comb begin
      event_d    = (event_q & ~clr_i) | qual;
      overflow_d = overflow_q;
      if (qual && event_q && !clr_i) begin
         overflow_d = 1'b1;
      end else if (clr_i) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         level_q      <= sig_i;
         prev_level_q <= sig_i;
         cnt_q        <= '0;
         event_q      <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         level_q      <= level_d;
         prev_level_q <= level_q;
         cnt_q        <= cnt_d;
         event_q      <= event_d;
         overflow_q   <= overflow_d;
      end
   end

   assign level_o    = level_q;
   assign rising_o   = rising;
   assign falling_o  = falling;
   assign event_o    = event_q;
   assign overflow_o = overflow_q;

endmodule

// File: rtl/edge_detector_multi.sv
// Multi-channel edge detector: WIDTH independent edge_chan instances
// plus the shared interrupt OR.
module edge_detector_multi
   import edge_pkg::*;
#(
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned FILTER_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [WIDTH-1:0]     sig_in,
   input  logic [2*WIDTH-1:0]   edge_mode,
   input  logic [WIDTH-1:0]     evt_clr,
   input  logic [WIDTH-1:0]     irq_en,
   output logic [WIDTH-1:0]     level,
   output logic [WIDTH-1:0]     rising,
   output logic [WIDTH-1:0]     falling,
   output logic [WIDTH-1:0]     event_o,
   output logic [WIDTH-1:0]     overflow,
   output logic                 irq
);

   generate
      if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
         $error("edge_detector_multi: WIDTH out of range");
      end
      if (SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
         $error("edge_detector_multi: SYNC_STAGES out of range");
      end
      if (FILTER_CYCLES < FILTER_CYCLES_MIN || FILTER_CYCLES > FILTER_CYCLES_MAX) begin : g_bad_filter
         $error("edge_detector_multi: FILTER_CYCLES out of range");
      end
   endgenerate

   generate
      for (genvar i = 0; i < int'(WIDTH); i++) begin : g_chan
         edge_chan #(
            .SYNC_STAGES   (SYNC_STAGES),
            .FILTER_CYCLES (FILTER_CYCLES)
         ) u_chan (
            .clk        (clk),
            .reset_n    (reset_n),
            .sig_i      (sig_in[i]),
            .mode_i     (edge_mode[2*i +: 2]),
            .clr_i      (evt_clr[i]),
            .level_o    (level[i]),
            .rising_o   (rising[i]),
            .falling_o  (falling[i]),
            .event_o    (event_o[i]),
            .overflow_o (overflow[i])
         );
      end
   endgenerate

   assign irq = |(event_o & irq_en);

endmodule

// File: tb/tb_edge_detector_multi.sv
// Directed and randomised bench for edge_detector_multi (4 channels,
// 2 sync stages, 3-cycle filter) with a per-cycle reference scoreboard.
module tb_edge_detector_multi;
   import edge_pkg::*;

   localparam int W  = 4;
   localparam int SS = 2;
   localparam int FC = 3;

   logic           clk = 1'b0;
   logic           reset_n;
   logic [W-1:0]   sig_in, evt_clr, irq_en;
   logic [2*W-1:0] edge_mode;
   logic [W-1:0]   level, rising, falling, event_o, overflow;
   logic           irq;

   always #5 clk = ~clk;

   edge_detector_multi #(
      .WIDTH         (W),
      .SYNC_STAGES   (SS),
      .FILTER_CYCLES (FC)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .sig_in    (sig_in),
      .edge_mode (edge_mode),
      .evt_clr   (evt_clr),
      .irq_en    (irq_en),
      .level     (level),
      .rising    (rising),
      .falling   (falling),
      .event_o   (event_o),
      .overflow  (overflow),
      .irq       (irq)
   );

   typedef struct packed {
      logic [W-1:0] lvl;
      logic [W-1:0] rise;
      logic [W-1:0] fall;
      logic [W-1:0] evt;
      logic [W-1:0] ovf;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference state: two-flop pipe, filtered level, its previous value, counters, flags.
   logic [W-1:0] m_s1, m_s2, m_lvl, m_prev, m_evt, m_ovf;
   int           m_cnt[W];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic model_edge();
      logic [W-1:0] r, f, q;
      exp_t e;
      r = m_lvl & ~m_prev;
      f = ~m_lvl & m_prev;
      if (!reset_n) begin
         m_s1   = sig_in;
         m_s2   = sig_in;
         m_lvl  = sig_in;
         m_prev = sig_in;
         m_evt  = '0;
         m_ovf  = '0;
         for (int c = 0; c < W; c++) m_cnt[c] = 0;
      end else begin
         for (int c = 0; c < W; c++) begin
            q[c] = (r[c] & edge_mode[2*c]) | (f[c] & edge_mode[2*c+1]);
         end
         m_ovf  = (m_ovf & ~evt_clr) | (q & m_evt & ~evt_clr);
         m_evt  = (m_evt & ~evt_clr) | q;
         m_prev = m_lvl;
         for (int c = 0; c < W; c++) begin
            if (m_s2[c] == m_lvl[c]) begin
               m_cnt[c] = 0;
            end else if (m_cnt[c] == FC - 1) begin
               m_lvl[c] = m_s2[c];
               m_cnt[c] = 0;
            end else begin
               m_cnt[c] = m_cnt[c] + 1;
            end
         end
         m_s2 = m_s1;
         m_s1 = sig_in;
      end
      e.lvl  = m_lvl;
      e.rise = m_lvl & ~m_prev;
      e.fall = ~m_lvl & m_prev;
      e.evt  = m_evt;
      e.ovf  = m_ovf;
      exp_q.push_back(e);
   endtask

   task automatic step();
      exp_t e;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (exp_q.size() == 0) begin
         check_val("sb_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check_val("sb_level",    32'(level),    32'(e.lvl));
         check_val("sb_rising",   32'(rising),   32'(e.rise));
         check_val("sb_falling",  32'(falling),  32'(e.fall));
         check_val("sb_event",    32'(event_o),  32'(e.evt));
         check_val("sb_overflow", 32'(overflow), 32'(e.ovf));
         check_val("sb_irq",      32'(irq),      32'(|(e.evt & irq_en)));
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      sig_in    = '0;
      edge_mode = '0;
      evt_clr   = '0;
      irq_en    = '0;
      repeat (3) step();
      check_val("rst_level",  32'(level),   32'h0);
      check_val("rst_event",  32'(event_o), 32'h0);
      check_val("rst_rising", 32'(rising),  32'h0);
      check_val("rst_irq",    32'(irq),     32'h0);
      reset_n = 1'b1;
      step();
      check_val("post_rst_pulses", 32'(rising | falling), 32'h0);

      // ch0 step, rising-only mode, interrupt enabled
      edge_mode = {EDGE_BOTH, EDGE_BOTH, EDGE_RISE, EDGE_RISE};
      irq_en    = 4'b0001;
      sig_in[0] = 1'b1;
      repeat (4) step();
      check_val("step_level_e3",  32'(level[0]),   32'd0);
      step();
      check_val("step_level_e4",  32'(level[0]),   32'd1);
      check_val("step_rising_e4", 32'(rising[0]),  32'd1);
      check_val("step_event_e4",  32'(event_o[0]), 32'd0);
      step();
      check_val("step_rising_e5", 32'(rising[0]),  32'd0);
      check_val("step_event_e5",  32'(event_o[0]), 32'd1);
      check_val("step_irq_e5",    32'(irq),        32'd1);

      // ch1 two-cycle glitch is filtered out
      sig_in[1] = 1'b1;
      repeat (2) step();
      sig_in[1] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step();
         check_val("glitch_rising", 32'(rising[1]), 32'd0);
      end
      check_val("glitch_level", 32'(level[1]),   32'd0);
      check_val("glitch_event", 32'(event_o[1]), 32'd0);

      // ch2 two qualifying edges without clear -> overflow, then clear both
      sig_in[2] = 1'b1;
      repeat (6) step();
      check_val("ovf_event_1", 32'(event_o[2]),  32'd1);
      check_val("ovf_ovf_1",   32'(overflow[2]), 32'd0);
      sig_in[2] = 1'b0;
      repeat (6) step();
      check_val("ovf_event_2", 32'(event_o[2]),  32'd1);
      check_val("ovf_ovf_2",   32'(overflow[2]), 32'd1);
      evt_clr[2] = 1'b1;
      step();
      evt_clr[2] = 1'b0;
      check_val("clr_event", 32'(event_o[2]),  32'd0);
      check_val("clr_ovf",   32'(overflow[2]), 32'd0);

      // ch3 qualifying edge coincident with clear: set wins, no overflow
      sig_in[3] = 1'b1;
      repeat (6) step();
      check_val("coin_event_pre", 32'(event_o[3]), 32'd1);
      sig_in[3] = 1'b0;
      repeat (5) step();
      check_val("coin_falling", 32'(falling[3]), 32'd1);
      evt_clr[3] = 1'b1;
      step();
      evt_clr[3] = 1'b0;
      check_val("coin_event", 32'(event_o[3]),  32'd1);
      check_val("coin_ovf",   32'(overflow[3]), 32'd0);
      edge_mode[7:6] = EDGE_NONE;
      step();
      check_val("mode_keeps_event", 32'(event_o[3]), 32'd1);

      // Static 1010 through reset release
      reset_n = 1'b0;
      sig_in  = 4'b1010;
      repeat (2) step();
      reset_n = 1'b1;
      step();
      check_val("rst1010_level", 32'(level), 32'hA);
      for (int k = 0; k < 6; k++) begin
         step();
         check_val("rst1010_pulses", 32'(rising | falling), 32'h0);
      end

      // Reset mid-filter discards the partial count
      sig_in[0] = 1'b1;
      repeat (4) step();
      check_val("midf_level_pre", 32'(level[0]), 32'd0);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         check_val("midf_pulses", 32'(rising | falling), 32'h0);
      end
      check_val("midf_level", 32'(level), 32'hB);

      // Randomised traffic, checked cycle by cycle against the reference
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(3) == 0) sig_in = W'($urandom);
         if ($urandom_range(15) == 0) edge_mode = (2*W)'($urandom);
         evt_clr = ($urandom_range(7) == 0) ? W'($urandom) : '0;
         irq_en  = ($urandom_range(7) == 0) ? W'($urandom) : irq_en;
         reset_n = ($urandom_range(99) != 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
